// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam int NB_PC_DEF   = 32;
    localparam int NB_INST_DEF = 32;
    localparam int NB_ADDR_DEF = 10;

    // Opcode field value that stops the pipeline.
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    // All-zero word is the pipeline bubble (sll $0,$0,0).
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    // Source selected for the next program counter.
    typedef enum logic [2:0] {
        PC_SEL_HOLD   = 3'd0,
        PC_SEL_BRANCH = 3'd1,
        PC_SEL_JR     = 3'd2,
        PC_SEL_JUMP   = 3'd3,
        PC_SEL_SEQ    = 3'd4
    } pc_sel_e;

    // True when the opcode field carries the HALT encoding.
    function automatic logic is_halt_op(input logic [5:0] opcode);
        return (opcode == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/if_stage_imem.sv
// Word-addressed instruction memory: combinational read, clocked write.
// Contents are deliberately not reset so a loaded program survives a
// pipeline reset.
module instruction_memory
    import if_stage_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_INST = NB_INST_DEF
) (
    input  logic               i_clock,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_INST-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_INST-1:0] o_rd_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_INST-1:0] mem_q [0:DEPTH-1];

    // Loader write port; a same-cycle read still sees the old word.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, instruction
// memory lookup, IF/ID pipeline register and sticky HALT flag.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int NB_PC   = NB_PC_DEF,
    parameter int NB_INST = NB_INST_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               i_IF_reset,
    input  logic               i_IF_enable,
    input  logic               i_IF_stall,
    input  logic               i_IF_flush,
    input  logic               i_IF_branch,
    input  logic [NB_PC-1:0]   i_IF_branch_addr,
    input  logic               i_IF_jump,
    input  logic [NB_PC-1:0]   i_IF_jump_addr,
    input  logic               i_IF_jr_jalr,
    input  logic [NB_PC-1:0]   i_IF_r31_data,
    input  logic               i_IF_wr_en,
    input  logic [NB_ADDR-1:0] i_IF_wr_addr,
    input  logic [NB_INST-1:0] i_IF_wr_data,
    output logic [NB_INST-1:0] o_IF_inst,
    output logic [NB_PC-1:0]   o_IF_pc,
    output logic [NB_PC-1:0]   o_IF_pc_current,
    output logic               o_IF_halt
);

    localparam logic [NB_PC-1:0]   PC_ONE   = {{(NB_PC-1){1'b0}}, 1'b1};
    localparam logic [NB_INST-1:0] NOP_INST = {NB_INST{1'b0}};

    logic [NB_PC-1:0]   pc_q, pc_d;
    logic [NB_INST-1:0] inst_q, inst_d;
    logic [NB_PC-1:0]   pc_out_q, pc_out_d;
    logic               halt_q, halt_d;

    logic [NB_INST-1:0] mem_rdata_s;
    logic [NB_PC-1:0]   pc_plus1_s;
    logic               redirect_s;
    logic               halt_fetch_s;
    logic               mem_wr_en_s;
    pc_sel_e            pc_sel_s;

    // The loader may only modify the program while the pipeline is frozen.
    assign mem_wr_en_s = i_IF_wr_en & ~i_IF_enable;

    instruction_memory #(
        .NB_ADDR (NB_ADDR),
        .NB_INST (NB_INST)
    ) u_imem (
        .i_clock   (i_clock),
        .i_wr_en   (mem_wr_en_s),
        .i_wr_addr (i_IF_wr_addr),
        .i_wr_data (i_IF_wr_data),
        .i_rd_addr (pc_q[NB_ADDR-1:0]),
        .o_rd_data (mem_rdata_s)
    );

    assign pc_plus1_s = pc_q + PC_ONE;
    assign redirect_s = i_IF_branch | i_IF_jr_jalr | i_IF_jump;

    // A HALT only counts when it actually lands in IF/ID this cycle.
    assign halt_fetch_s = i_IF_enable & ~halt_q & ~redirect_s & ~i_IF_stall
                        & ~i_IF_flush & is_halt_op(mem_rdata_s[NB_INST-1 -: 6]);

    // Next-PC source priority: freeze, halt, branch (older instr), jr, jump, stall.
    always_comb begin
        pc_sel_s = PC_SEL_HOLD;
        if (!i_IF_enable) begin
            pc_sel_s = PC_SEL_HOLD;
        end else if (halt_q) begin
            pc_sel_s = PC_SEL_HOLD;
        end else if (i_IF_branch) begin
            pc_sel_s = PC_SEL_BRANCH;
        end else if (i_IF_jr_jalr) begin
            pc_sel_s = PC_SEL_JR;
        end else if (i_IF_jump) begin
            pc_sel_s = PC_SEL_JUMP;
        end else if (i_IF_stall || halt_fetch_s) begin
            pc_sel_s = PC_SEL_HOLD;
        end else begin
            pc_sel_s = PC_SEL_SEQ;
        end
    end

    // Next-PC mux driven by the selected source.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel_s)
            PC_SEL_HOLD:   pc_d = pc_q;
            PC_SEL_BRANCH: pc_d = i_IF_branch_addr;
            PC_SEL_JR:     pc_d = i_IF_r31_data;
            PC_SEL_JUMP:   pc_d = i_IF_jump_addr;
            PC_SEL_SEQ:    pc_d = pc_plus1_s;
            default:       pc_d = pc_q;
        endcase
    end

    // IF/ID next value: redirects squash the wrong-path fetch with a NOP.
    always_comb begin
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        if (!i_IF_enable) begin
            inst_d   = inst_q;
            pc_out_d = pc_out_q;
        end else if (i_IF_flush || redirect_s) begin
            inst_d   = NOP_INST;
            pc_out_d = pc_plus1_s;
        end else if (halt_q || i_IF_stall) begin
            inst_d   = inst_q;
            pc_out_d = pc_out_q;
        end else begin
            inst_d   = mem_rdata_s;
            pc_out_d = pc_plus1_s;
        end
    end

    // Halt flag is sticky until reset.
    always_comb begin
        if (halt_q) begin
            halt_d = 1'b1;
        end else begin
            halt_d = halt_fetch_s;
        end
    end

    // All fetch-stage state, cleared asynchronously.
    always_ff @(posedge i_clock or posedge i_IF_reset) begin
        if (i_IF_reset) begin
            pc_q     <= {NB_PC{1'b0}};
            inst_q   <= NOP_INST;
            pc_out_q <= {NB_PC{1'b0}};
            halt_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            halt_q   <= halt_d;
        end
    end

    assign o_IF_inst       = inst_q;
    assign o_IF_pc         = pc_out_q;
    assign o_IF_pc_current = pc_q;
    assign o_IF_halt       = halt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of per-cycle vectors plus
// hand-written sequences, with expected outputs queued as each cycle is driven.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, stall, flush, branch, jump, jr, wr_en;
    logic [31:0] baddr, jaddr, raddr, wdata;
    logic [9:0]  waddr;
    logic [31:0] o_inst, o_pc, o_cur;
    logic        o_halt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        en, stall, flush, branch, jump, jr, wr_en;
        logic [31:0] baddr, jaddr, raddr;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] e_inst, e_pc, e_cur;
        logic        e_halt;
    } vec_t;

    typedef struct packed {
        logic [31:0] inst, pc, cur;
        logic        halt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    if_stage dut (
        .i_clock          (clk),
        .i_IF_reset       (rst),
        .i_IF_enable      (en),
        .i_IF_stall       (stall),
        .i_IF_flush       (flush),
        .i_IF_branch      (branch),
        .i_IF_branch_addr (baddr),
        .i_IF_jump        (jump),
        .i_IF_jump_addr   (jaddr),
        .i_IF_jr_jalr     (jr),
        .i_IF_r31_data    (raddr),
        .i_IF_wr_en       (wr_en),
        .i_IF_wr_addr     (waddr),
        .i_IF_wr_data     (wdata),
        .o_IF_inst        (o_inst),
        .o_IF_pc          (o_pc),
        .o_IF_pc_current  (o_cur),
        .o_IF_halt        (o_halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t nv(input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] c, input logic h);
        vec_t v;
        v = '0;
        v.en = 1'b1;
        v.e_inst = i;
        v.e_pc = p;
        v.e_cur = c;
        v.e_halt = h;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, sample after the edge and compare.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        en = v.en; stall = v.stall; flush = v.flush;
        branch = v.branch; baddr = v.baddr;
        jump = v.jump; jaddr = v.jaddr;
        jr = v.jr; raddr = v.raddr;
        wr_en = v.wr_en; waddr = v.waddr; wdata = v.wdata;
        sb.push_back('{inst: v.e_inst, pc: v.e_pc, cur: v.e_cur, halt: v.e_halt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".inst"}, o_inst, e.inst);
        check({tag, ".pc"},   o_pc,   e.pc);
        check({tag, ".cur"},  o_cur,  e.cur);
        check({tag, ".halt"}, {31'd0, o_halt}, {31'd0, e.halt});
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        wr_en = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0;
        branch = 1'b0; jump = 1'b0; jr = 1'b0; wr_en = 1'b0;
        baddr = 32'd0; jaddr = 32'd0; raddr = 32'd0; waddr = 10'd0; wdata = 32'd0;

        // Program load while frozen (and held in reset).
        load(10'd0,   32'h0000_0011);
        load(10'd1,   32'h0000_0022);
        load(10'd2,   32'h0000_0033);
        load(10'd3,   32'h0000_0044);
        load(10'd4,   32'h4444_0000);
        load(10'd5,   32'h0000_0055);
        load(10'd6,   32'hFC00_0000);
        load(10'd7,   32'h0000_0077);
        load(10'd20,  32'h0000_00AA);
        load(10'd21,  32'h0000_00BB);
        load(10'd1023, 32'h3FF3_FF00);

        check("reset.inst", o_inst, 32'd0);
        check("reset.pc",   o_pc,   32'd0);
        check("reset.cur",  o_cur,  32'd0);
        check("reset.halt", {31'd0, o_halt}, 32'd0);
        rst = 1'b0;

        // Main table.
        tbl.push_back(nv(32'h11, 32'd1, 32'd1, 1'b0));
        tbl.push_back(nv(32'h22, 32'd2, 32'd2, 1'b0));
        v = nv(32'h22, 32'd2, 32'd2, 1'b0); v.stall = 1'b1; tbl.push_back(v);
        v = nv(32'h22, 32'd2, 32'd2, 1'b0); v.stall = 1'b1; tbl.push_back(v);
        tbl.push_back(nv(32'h33, 32'd3, 32'd3, 1'b0));
        v = nv(32'h0, 32'd4, 32'd4, 1'b0); v.flush = 1'b1; tbl.push_back(v);
        v = nv(32'h0, 32'd5, 32'd20, 1'b0);
        v.jump = 1'b1; v.jaddr = 32'd8; v.branch = 1'b1; v.baddr = 32'd20; tbl.push_back(v);
        tbl.push_back(nv(32'hAA, 32'd21, 32'd21, 1'b0));
        v = nv(32'h0, 32'd22, 32'd5, 1'b0);
        v.jr = 1'b1; v.raddr = 32'd5; v.stall = 1'b1; tbl.push_back(v);
        tbl.push_back(nv(32'h55, 32'd6, 32'd6, 1'b0));
        v = nv(32'h55, 32'd6, 32'd6, 1'b0); v.stall = 1'b1; tbl.push_back(v);
        tbl.push_back(nv(32'hFC00_0000, 32'd7, 32'd6, 1'b1));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(nv(32'hFC00_0000, 32'd7, 32'd6, 1'b1));
        end
        v = nv(32'h0, 32'd7, 32'd6, 1'b1); v.branch = 1'b1; v.baddr = 32'd20; tbl.push_back(v);
        tbl.push_back(nv(32'h0, 32'd7, 32'd6, 1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset pulse in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.inst", o_inst, 32'd0);
        check("async_rst.pc",   o_pc,   32'd0);
        check("async_rst.cur",  o_cur,  32'd0);
        check("async_rst.halt", {31'd0, o_halt}, 32'd0);
        #1;
        rst = 1'b0;

        // Loader gating, same-cycle old read, aliasing and PC wrap.
        v = nv(32'h11, 32'd1, 32'd1, 1'b0);
        v.wr_en = 1'b1; v.waddr = 10'd3; v.wdata = 32'hDEAD_0001;
        run_vec(v, "ld_en1");
        run_vec(nv(32'h22, 32'd2, 32'd2, 1'b0), "ld_a");
        run_vec(nv(32'h33, 32'd3, 32'd3, 1'b0), "ld_b");
        run_vec(nv(32'h44, 32'd4, 32'd4, 1'b0), "ld_unchanged");
        v = nv(32'h44, 32'd4, 32'd4, 1'b0);
        v.en = 1'b0; v.wr_en = 1'b1; v.waddr = 10'd3; v.wdata = 32'hCAFE_0003;
        run_vec(v, "ld_en0_frozen");
        v = nv(32'h0, 32'd5, 32'd3, 1'b0); v.jump = 1'b1; v.jaddr = 32'd3;
        run_vec(v, "ld_jump_back");
        run_vec(nv(32'hCAFE_0003, 32'd4, 32'd4, 1'b0), "ld_new_word");
        v = nv(32'h0, 32'd5, 32'h401, 1'b0); v.jump = 1'b1; v.jaddr = 32'h401;
        run_vec(v, "alias_jump");
        run_vec(nv(32'h22, 32'h402, 32'h402, 1'b0), "alias_fetch");
        v = nv(32'h0, 32'h403, 32'hFFFF_FFFF, 1'b0); v.jump = 1'b1; v.jaddr = 32'hFFFF_FFFF;
        run_vec(v, "wrap_jump");
        run_vec(nv(32'h3FF3_FF00, 32'd0, 32'd0, 1'b0), "wrap_fetch");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# IF_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, selects the next PC from sequential, branch, jump and register-jump sources, reads a word-addressed instruction memory, and registers the fetched instruction plus PC+1 into the IF/ID pipeline register. Supports stall, flush, program loading while the pipeline is halted, and HALT-opcode detection.

## Interface
- NB_PC, 32, PC and target-address width
- NB_INST, 32, instruction width
- NB_ADDR, 10, instruction-memory address width (2^NB_ADDR words)
- i_clock  in  1  single clock, all state on rising edge
- i_IF_reset  in  1  asynchronous, active-high reset
- i_IF_enable  in  1  run enable from the debug unit; 0 freezes all IF state
- i_IF_stall  in  1  load-use stall from the hazard unit; holds PC and IF/ID
- i_IF_flush  in  1  control-hazard flush; IF/ID loads a NOP
- i_IF_branch  in  1  taken branch, resolved downstream
- i_IF_branch_addr  in  NB_PC  branch target
- i_IF_jump  in  1  J/JAL from decode
- i_IF_jump_addr  in  NB_PC  concatenated jump target from decode
- i_IF_jr_jalr  in  1  JR/JALR from decode
- i_IF_r31_data  in  NB_PC  register-jump target from decode
- i_IF_wr_en  in  1  instruction-memory write strobe (loader)
- i_IF_wr_addr  in  NB_ADDR  write word address
- i_IF_wr_data  in  NB_INST  write data
- o_IF_inst  out  NB_INST  IF/ID instruction
- o_IF_pc  out  NB_PC  IF/ID PC+1
- o_IF_pc_current  out  NB_PC  live PC register (debug)
- o_IF_halt  out  1  HALT fetched; sticky until reset

## Operation
- PC is word-addressed; sequential next PC = PC + 1, modulo 2^NB_PC.
- Memory read is asynchronous, indexed by PC[NB_ADDR-1:0]; upper PC bits ignored (aliasing).
- Next-PC priority, highest first: reset; i_IF_enable=0 (hold); halt latched (hold); i_IF_branch; i_IF_jr_jalr; i_IF_jump; i_IF_stall (hold); PC+1. Branch wins because it comes from the older instruction; any redirect overrides a simultaneous stall.
- IF/ID priority: reset; enable=0 (hold); i_IF_flush or any redirect (load inst=0 NOP, pc=PC+1); halt latched (hold); stall (hold); else load mem[PC] and PC+1.
- HALT = opcode 6'b111111 in inst[31:26] of the word being fetched. When fetched with enable=1 and no stall/redirect: HALT is loaded into IF/ID, PC not advanced, halt flag set. A HALT fetched in a redirect or stall cycle does not set the flag.
- Loader writes take effect only when i_IF_enable=0; ignored otherwise. Write and read of the same address in one cycle: read returns old data; new data is visible next cycle.
- Memory contents are not cleared by reset.

## Timing
- Reset values: PC=0, o_IF_inst=0, o_IF_pc=0, o_IF_halt=0; o_IF_pc_current=0. Reset mid-run returns to these immediately (asynchronous), regardless of stall/flush/halt.
- Fetch latency: instruction at PC appears on o_IF_inst one clock edge after PC holds that value.
- Redirect: target is in PC the edge after the redirect input is sampled; the wrong-path instruction in IF is replaced by NOP on that same edge.
- Stall: PC and IF/ID hold for every stalled cycle; release resumes fetching without a bubble.
- Halt: o_IF_halt rises on the edge that loads HALT into IF/ID and stays high until reset.

## Structure
- Shared constants header: HALT opcode (6'b111111), NOP word (32'h0), default widths.
- One sub-module: instruction_memory (async read, sync write, NB_ADDR/NB_INST parameters).
- PC register, next-PC mux, IF/ID register and halt flag stay in IF_stage.

## Test plan
- Load mem[0..3]=32'h11,22,33,44 with enable=0, reset, enable=1 -> o_IF_inst 0x11,0x22,0x33 on successive edges, o_IF_pc 1,2,3.
- Stall asserted 2 cycles while PC=2 -> PC stays 2, o_IF_inst stays 0x22; release -> next edge 0x33, o_IF_pc=3.
- i_IF_jump=1, jump_addr=8 together with i_IF_branch=1, branch_addr=20 -> PC=20, o_IF_inst=0 (NOP) that edge, mem[20] next edge.
- i_IF_jr_jalr=1, r31_data=5, i_IF_stall=1 same cycle -> PC=5, IF/ID=NOP.
- mem[6]=32'hFC000000, fetch reaches PC=6 -> o_IF_halt=1, o_IF_inst=0xFC000000, PC stays 6 for 10 cycles; i_IF_reset pulse mid-cycle -> PC=0, halt=0 immediately.
- Loader write to addr 3 with enable=1 -> mem[3] unchanged; with enable=0 -> updated, read returns old value same cycle, new value next cycle.
